// File: rtl/gdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gdiv_pkg
// Purpose : Shared types and helpers for the multi-channel gated divider.
// Revision: 1.0 - initial release
// ============================================================================
package gdiv_pkg;

    typedef enum logic {
        GDIV_UNI = 1'b0,
        GDIV_BI  = 1'b1
    } gdiv_mode_e;

    // Mid-scale start point: quotient probability 0.5 (value 0 in bipolar).
    function automatic int gdiv_default_init(input int dep);
        return 1 << (dep - 1);
    endfunction

endpackage : gdiv_pkg
`default_nettype wire

// File: rtl/gdiv_mc_ch.sv
`default_nettype none
// ============================================================================
// Module  : gdiv_mc_ch
// Purpose : One stochastic divider channel: saturating counter, compare,
//           decrement feedback, sticky saturation flags, optional output reg.
// Revision: 1.0 - initial release
// ============================================================================
module gdiv_mc_ch
    import gdiv_pkg::*;
#(
    parameter int DEP     = 5,
    parameter int INIT    = gdiv_default_init(DEP),
    parameter int OUT_REG = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic           clr_i,
    input  gdiv_mode_e     mode_i,
    input  logic [DEP-1:0] rand_i,
    input  logic           dividend_i,
    input  logic           divisor_i,
    output logic           quotient_o,
    output logic           sat_hi_o,
    output logic           sat_lo_o
);

    localparam logic [DEP-1:0] c_INIT = DEP'(INIT);
    localparam logic [DEP-1:0] c_MAX  = {DEP{1'b1}};
    localparam logic [DEP-1:0] c_ZERO = '0;
    localparam logic [DEP-1:0] c_ONE  = DEP'(1);

    logic [DEP-1:0] cnt_q, cnt_d;
    logic           sat_hi_q, sat_hi_d;
    logic           sat_lo_q, sat_lo_d;
    logic           w_q_raw;
    logic           w_inc;
    logic           w_dec;

    always_comb begin
        w_q_raw = (cnt_q > rand_i);
        w_inc   = dividend_i;
        // Bipolar multiply of two streams is XNOR; unipolar is AND.
        if (mode_i == GDIV_BI) begin
            w_dec = ~(w_q_raw ^ divisor_i);
        end else begin
            w_dec = w_q_raw & divisor_i;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        sat_hi_d = sat_hi_q;
        sat_lo_d = sat_lo_q;
        if (clr_i) begin
            cnt_d    = c_INIT;
            sat_hi_d = 1'b0;
            sat_lo_d = 1'b0;
        end else if (en_i) begin
            if (w_inc && !w_dec) begin
                if (cnt_q == c_MAX) begin
                    sat_hi_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end else if (!w_inc && w_dec) begin
                if (cnt_q == c_ZERO) begin
                    sat_lo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - c_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= c_INIT;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sat_hi_q <= sat_hi_d;
            sat_lo_q <= sat_lo_d;
        end
    end

    assign sat_hi_o = sat_hi_q;
    assign sat_lo_o = sat_lo_q;

    // Feedback always uses w_q_raw, so registering only delays the output.
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic quot_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    quot_q <= 1'b0;
                end else begin
                    quot_q <= w_q_raw;
                end
            end
            assign quotient_o = quot_q;
        end else begin : g_out_comb
            assign quotient_o = w_q_raw;
        end
    endgenerate

endmodule : gdiv_mc_ch
`default_nettype wire

// File: rtl/gdiv_mc.sv
`default_nettype none
// ============================================================================
// Module  : gdiv_mc
// Purpose : Multi-channel unipolar/bipolar stochastic divider; distributes
//           shared or per-channel random numbers to independent channels.
// Revision: 1.0 - initial release
// ============================================================================
module gdiv_mc
    import gdiv_pkg::*;
#(
    parameter int CH         = 4,
    parameter int DEP        = 5,
    parameter int INIT       = gdiv_default_init(DEP),
    parameter int SHARED_RNG = 1,
    parameter int OUT_REG    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH-1:0]     en_i,
    input  logic [CH-1:0]     clr_i,
    input  logic [CH-1:0]     mode_i,
    input  logic [CH*DEP-1:0] rand_num_i,
    input  logic [CH-1:0]     dividend_i,
    input  logic [CH-1:0]     divisor_i,
    output logic [CH-1:0]     quotient_o,
    output logic [CH-1:0]     sat_hi_o,
    output logic [CH-1:0]     sat_lo_o
);

    generate
        if (SHARED_RNG != 0) begin : g_rng_shared
            // Upper slices are ignored when every channel shares slice 0.
            logic w_unused_rand;
            assign w_unused_rand = ^rand_num_i;
        end
    endgenerate

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            logic [DEP-1:0] w_rand;

            if (SHARED_RNG != 0) begin : g_sel_shared
                assign w_rand = rand_num_i[DEP-1:0];
            end else begin : g_sel_own
                assign w_rand = rand_num_i[i*DEP +: DEP];
            end

            gdiv_mc_ch #(
                .DEP     (DEP),
                .INIT    (INIT),
                .OUT_REG (OUT_REG)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .en_i       (en_i[i]),
                .clr_i      (clr_i[i]),
                .mode_i     (gdiv_mode_e'(mode_i[i])),
                .rand_i     (w_rand),
                .dividend_i (dividend_i[i]),
                .divisor_i  (divisor_i[i]),
                .quotient_o (quotient_o[i]),
                .sat_hi_o   (sat_hi_o[i]),
                .sat_lo_o   (sat_lo_o[i])
            );
        end
    endgenerate

endmodule : gdiv_mc
`default_nettype wire
